// File: rtl/cong_nbit_tuantu_if.sv
// Operand/result bundle for cong_nbit_tuantu.
//   master: drives start/a/b/cin/sub, observes s/cout/ovf/busy/done
//   slave : the adder itself
//   start  request, sampled only while idle
//   a, b   operands; cin carry/borrow-in; sub selects A-B-CIN
//   s      registered result, held until the next DONE
//   cout   raw carry out of the MSB (sub mode: 1 = no borrow)
//   ovf    two's-complement overflow; busy op in flight; done 1-cycle pulse
interface cong_nbit_tuantu_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin, sub,
    input  s, cout, ovf, busy, done
  );

  modport slave (
    input  start, a, b, cin, sub,
    output s, cout, ovf, busy, done
  );
endinterface

// File: rtl/cong_nbit_tuantu.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands added CHUNK bits per clock,
// least significant slice first, with a START/BUSY/DONE handshake.
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   bus_io  slave side of cong_nbit_tuantu_if (operands in, result/flags out)
// Latency from the accepting edge to DONE is WIDTH/CHUNK cycles; a START in
// the DONE cycle is accepted, so back-to-back operations have no gap.
module cong_nbit_tuantu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  cong_nbit_tuantu_if.slave bus_io
);

  localparam int unsigned Steps = WIDTH / CHUNK;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Steps - 1);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  logic             state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;   // already inverted in subtract mode
  logic             c_q, c_d;
  logic [CntW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
  logic             c_out, c_msb;
  logic [WIDTH-1:0] acc_nx;

  // Operands are shifted right each step, so the live slice is always at the bottom.
  assign a_sl = a_q[CHUNK-1:0];
  assign b_sl = b_q[CHUNK-1:0];
  assign {c_out, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK + 1)'(c_q);
  // Carry into the slice MSB recovered from its sum bit: a ^ b ^ s.
  assign c_msb = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sum_sl[CHUNK-1];
  // New slice enters at the top of acc; after Steps shifts it is fully aligned.
  assign acc_nx = WIDTH'({sum_sl, acc_q} >> CHUNK);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          a_d     = bus_io.a;
          b_d     = bus_io.sub ? ~bus_io.b : bus_io.b;
          c_d     = bus_io.sub ? ~bus_io.cin : bus_io.cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        c_d   = c_out;
        acc_d = acc_nx;
        idx_d = idx_q + CntW'(1);
        if (idx_q == LastIdx) begin
          s_d     = acc_nx;
          cout_d  = c_out;
          ovf_d   = c_msb ^ c_out;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus_io.s    = s_q;
  assign bus_io.cout = cout_q;
  assign bus_io.ovf  = ovf_q;
  assign bus_io.busy = (state_q == StRun);
  assign bus_io.done = done_q;

endmodule

// File: tb/tb_cong_nbit_tuantu.sv
// Bench for cong_nbit_tuantu: three instances (CHUNK = 1, 4, 16; WIDTH = 16).
// Drivers push expected results (with the cycle DONE is due) into per-instance
// queues; a negedge monitor pops and compares whenever DONE is seen, and checks
// that results hold steady otherwise.
module tb_cong_nbit_tuantu;

  localparam int unsigned W = 16;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus and observation arrays, index 0/1/2 = CHUNK 1/4/16.
  logic        st   [3];
  logic [15:0] ia   [3];
  logic [15:0] ib   [3];
  logic        icin [3];
  logic        isub [3];
  logic [15:0] o_s    [3];
  logic        o_cout [3];
  logic        o_ovf  [3];
  logic        o_busy [3];
  logic        o_done [3];

  int steps [3] = '{16, 4, 1};

  cong_nbit_tuantu_if #(.WIDTH(W)) bus0 ();
  cong_nbit_tuantu_if #(.WIDTH(W)) bus1 ();
  cong_nbit_tuantu_if #(.WIDTH(W)) bus2 ();

  cong_nbit_tuantu #(.WIDTH(W), .CHUNK(1))  dut0 (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus0));
  cong_nbit_tuantu #(.WIDTH(W), .CHUNK(4))  dut1 (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus1));
  cong_nbit_tuantu #(.WIDTH(W), .CHUNK(16)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus2));

  assign bus0.start = st[0];   assign bus1.start = st[1];   assign bus2.start = st[2];
  assign bus0.a     = ia[0];   assign bus1.a     = ia[1];   assign bus2.a     = ia[2];
  assign bus0.b     = ib[0];   assign bus1.b     = ib[1];   assign bus2.b     = ib[2];
  assign bus0.cin   = icin[0]; assign bus1.cin   = icin[1]; assign bus2.cin   = icin[2];
  assign bus0.sub   = isub[0]; assign bus1.sub   = isub[1]; assign bus2.sub   = isub[2];
  assign o_s[0]    = bus0.s;    assign o_s[1]    = bus1.s;    assign o_s[2]    = bus2.s;
  assign o_cout[0] = bus0.cout; assign o_cout[1] = bus1.cout; assign o_cout[2] = bus2.cout;
  assign o_ovf[0]  = bus0.ovf;  assign o_ovf[1]  = bus1.ovf;  assign o_ovf[2]  = bus2.ovf;
  assign o_busy[0] = bus0.busy; assign o_busy[1] = bus1.busy; assign o_busy[2] = bus2.busy;
  assign o_done[0] = bus0.done; assign o_done[1] = bus1.done; assign o_done[2] = bus2.done;

  exp_t sb_q [3][$];
  exp_t last_exp [3];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, int i, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h (cycle %0d)", name, i, act, req, cyc);
    end
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.s = '0; e.cout = 1'b0; e.ovf = 1'b0; e.due = 0;
    return e;
  endfunction

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic cin, logic sub, int due);
    exp_t e;
    int   ua, ub, ur, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      ur = ua - ub - int'(cin);
      sr = sa - sb - int'(cin);
      e.cout = (ur >= 0);
    end else begin
      ur = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      e.cout = (ur >= 65536);
    end
    e.s   = ur[15:0];
    e.ovf = (sr > 32767) || (sr < -32768);
    e.due = due;
    return e;
  endfunction

  // Monitor: scoreboard pop on DONE, hold check otherwise.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (o_busy[i] && o_done[i]) chk("busy_and_done", i, 1, 0);
      if (o_done[i]) begin
        if (sb_q[i].size() == 0) begin
          chk("unexpected_done", i, 1, 0);
        end else begin
          exp_t e;
          e = sb_q[i].pop_front();
          chk("s", i, o_s[i], e.s);
          chk("cout", i, o_cout[i], e.cout);
          chk("ovf", i, o_ovf[i], e.ovf);
          chk("done_cycle", i, cyc, e.due);
          last_exp[i] = e;
        end
      end else begin
        chk("s_hold", i, o_s[i], last_exp[i].s);
        chk("flags_hold", i, {o_cout[i], o_ovf[i]}, {last_exp[i].cout, last_exp[i].ovf});
        if (sb_q[i].size() != 0 && cyc > sb_q[i][0].due) begin
          chk("done_missing", i, cyc, sb_q[i][0].due);
          void'(sb_q[i].pop_front());
        end
      end
    end
  end

  // Called at a negedge; waits for idle, drives START and leaves it high.
  // Returns at the negedge after the accepting edge.
  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input bit directed,
                       input logic [15:0] es, input logic ec, input logic eo);
    int   n;
    exp_t e;
    n = 0;
    while (o_busy[i]) begin
      @(negedge clk);
      n++;
      if (n > 64) begin
        chk("idle_timeout", i, 1, 0);
        return;
      end
    end
    ia[i] = a; ib[i] = b; icin[i] = cin; isub[i] = sub; st[i] = 1'b1;
    if (directed) begin
      e.s = es; e.cout = ec; e.ovf = eo; e.due = cyc + 1 + steps[i];
    end else begin
      e = model(a, b, cin, sub, cyc + 1 + steps[i]);
    end
    sb_q[i].push_back(e);
    @(negedge clk);
  endtask

  task automatic dir(input logic [15:0] a, input logic [15:0] b, input logic cin,
                     input logic sub, input logic [15:0] es, input logic ec, input logic eo);
    issue(1, a, b, cin, sub, 1'b1, es, ec, eo);
    st[1] = 1'b0;
  endtask

  task automatic run_random(input int i);
    for (int k = 0; k < 1000; k++) begin
      issue(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, 1'b0, 1'b0);
      st[i] = 1'b0;
      // Junk START while busy must be ignored.
      if ($urandom_range(0, 3) == 0 && o_busy[i]) begin
        st[i] = 1'b1; ia[i] = 16'($urandom); ib[i] = 16'($urandom);
        icin[i] = 1'($urandom); isub[i] = 1'($urandom);
        @(negedge clk);
        st[i] = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; ia[i] = '0; ib[i] = '0; icin[i] = 1'b0; isub[i] = 1'b0;
      last_exp[i] = zero_exp();
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("reset_s", i, o_s[i], 16'h0);
      chk("reset_flags", i, {o_cout[i], o_ovf[i], o_busy[i], o_done[i]}, 4'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases on the CHUNK=4 instance.
    dir(16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0);
    dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    dir(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // START mid-RUN with other operands is ignored.
    dir(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    st[1] = 1'b1; ia[1] = 16'hAAAA; ib[1] = 16'h5555; isub[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;

    // START held through DONE: second op accepted on the DONE edge.
    issue(1, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b1, 16'h0300, 1'b0, 1'b0);
    issue(1, 16'hF000, 16'h1001, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
    st[1] = 1'b0;

    // Reset two cycles into RUN discards the op.
    issue(1, 16'h4444, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    st[1] = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_q[i].delete();
      last_exp[i] = zero_exp();
    end
    #1;
    chk("midrst_s", 1, o_s[1], 16'h0);
    chk("midrst_flags", 1, {o_cout[1], o_ovf[1], o_busy[1], o_done[1]}, 4'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dir(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Random sweep on all three widths of slice.
    fork
      run_random(0);
      run_random(1);
      run_random(2);
    join

    n = 0;
    while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) chk("drain", i, sb_q[i].size(), 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
